// File: rtl/regfile_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_buffer
// Description : Write-back FIFO in front of the 32-entry register file write
//               port. It drains one entry per cycle and forwards pending values
//               to read ports A and B.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_buffer #(
    parameter int WORDSIZE = 64,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_addr,
    input  logic [WORDSIZE-1:0]          in_data,
    input  logic                         drain_hold,
    output logic                         write_en,
    output logic [4:0]                   write_addr,
    output logic [WORDSIZE-1:0]          write_data,
    input  logic [4:0]                   addr_a,
    input  logic [4:0]                   addr_b,
    output logic                         fwd_hit_a,
    output logic [WORDSIZE-1:0]          fwd_data_a,
    output logic                         fwd_hit_b,
    output logic [WORDSIZE-1:0]          fwd_data_b,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic [4:0]          r_addr [DEPTH];
    logic [WORDSIZE-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_wr_en;
    logic [4:0]          r_wr_addr;
    logic [WORDSIZE-1:0] r_wr_data;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [c_ptr_w-1:0]  w_idx;
    logic                w_hit_a;
    logic                w_hit_b;
    logic [WORDSIZE-1:0] w_fwd_a;
    logic [WORDSIZE-1:0] w_fwd_b;

    assign w_full   = (r_count == c_cnt_w'(DEPTH));
    assign in_ready = !w_full;
    // x0 requests complete the handshake but never enter the FIFO.
    assign w_push   = in_valid && !w_full && (in_addr != 5'd0);
    assign w_pop    = (r_count != '0) && !drain_hold;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= in_addr;
            r_data[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_wr_en         <= 1'b1;
                r_wr_addr       <= r_addr[r_head];
                r_wr_data       <= r_data[r_head];
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_w'(1);
            end else begin
                r_wr_en <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk from oldest (output register) to youngest (tail-1); later matches win.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_fwd_a = '0;
        w_fwd_b = '0;
        w_idx   = '0;
        if (r_wr_en && (r_wr_addr == addr_a) && (addr_a != 5'd0)) begin
            w_hit_a = 1'b1;
            w_fwd_a = r_wr_data;
        end
        if (r_wr_en && (r_wr_addr == addr_b) && (addr_b != 5'd0)) begin
            w_hit_b = 1'b1;
            w_fwd_b = r_wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_ptr_w'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == addr_a) && (addr_a != 5'd0)) begin
                w_hit_a = 1'b1;
                w_fwd_a = r_data[w_idx];
            end
            if (r_valid[w_idx] && (r_addr[w_idx] == addr_b) && (addr_b != 5'd0)) begin
                w_hit_b = 1'b1;
                w_fwd_b = r_data[w_idx];
            end
        end
    end

    assign write_en   = r_wr_en;
    assign write_addr = r_wr_addr;
    assign write_data = r_wr_data;
    assign fwd_hit_a  = w_hit_a;
    assign fwd_data_a = w_fwd_a;
    assign fwd_hit_b  = w_hit_b;
    assign fwd_data_b = w_fwd_b;
    assign count      = r_count;
    assign empty      = (r_count == '0);
    assign full       = w_full;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback_buffer
// Description : Scoreboard bench for regfile_writeback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_buffer;

    localparam int WORDSIZE = 64;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4:0]          in_addr = '0;
    logic [WORDSIZE-1:0] in_data = '0;
    logic                drain_hold = 1'b0;
    logic                write_en;
    logic [4:0]          write_addr;
    logic [WORDSIZE-1:0] write_data;
    logic [4:0]          addr_a = '0;
    logic [4:0]          addr_b = '0;
    logic                fwd_hit_a;
    logic [WORDSIZE-1:0] fwd_data_a;
    logic                fwd_hit_b;
    logic [WORDSIZE-1:0] fwd_data_b;
    logic [2:0]          count;
    logic                empty;
    logic                full;

    int checks   = 0;
    int failures = 0;
    int n_writes = 0;
    logic [4+WORDSIZE:0] sb [$];

    regfile_writeback_buffer #(.WORDSIZE(WORDSIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_hold(drain_hold),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .addr_a(addr_a), .addr_b(addr_b), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b), .count(count),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Record accepted non-x0 requests just before the edge that transfers them.
    always @(negedge clk) begin
        if (reset && in_valid && in_ready && in_addr != 5'd0)
            sb.push_back({1'b0, in_addr, in_data});
    end

    // Every register-file write must match the oldest outstanding acceptance.
    always @(posedge clk) begin
        logic [4+WORDSIZE:0] exp;
        #1;
        if (write_en === 1'b1) begin
            n_writes++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%0h, required no write", write_addr, write_data);
            end else begin
                exp = sb.pop_front();
                if ({1'b0, write_addr, write_data} !== exp) begin
                    failures++;
                    $display("FAIL sb_write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                             write_addr, write_data, exp[4+WORDSIZE-1 -: 5], exp[WORDSIZE-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({write_en, write_addr, write_data, count, empty, full, in_ready} !==
            {1'b0, 5'd0, 64'd0, 3'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got en=%b addr=%0d data=%0h count=%0d empty=%b full=%b rdy=%b, required 0/0/0/0/1/0/1",
                     write_en, write_addr, write_data, count, empty, full, in_ready);
        end
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        in_valid = 1'b1; in_addr = 5'd5; in_data = 64'h1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd1 || write_en !== 1'b0) begin
            failures++;
            $display("FAIL single_edge1: got count=%0d en=%b, required count=1 en=0", count, write_en);
        end
        tick();
        checks++;
        if (write_en !== 1'b1 || write_addr !== 5'd5 || write_data !== 64'h1234 || count !== 3'd0) begin
            failures++;
            $display("FAIL single_edge2: got en=%b addr=%0d data=%0h count=%0d, required 1/5/1234/0",
                     write_en, write_addr, write_data, count);
        end
        tick();
        checks++;
        if (write_en !== 1'b0) begin
            failures++;
            $display("FAIL single_edge3: got en=%b, required 0", write_en);
        end
    endtask

    task automatic test_x0_discard();
        int peak = 0;
        addr_a = 5'd0;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 64'hDEAD;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready: got %b, required 1", in_ready);
        end
        tick();
        checks++;
        if (count !== 3'd0 || fwd_hit_a !== 1'b0) begin
            failures++;
            $display("FAIL x0_not_stored: got count=%0d hit_a=%b, required 0/0", count, fwd_hit_a);
        end
        in_addr = 5'd3; in_data = 64'd7;
        tick();
        in_valid = 1'b0;
        addr_a = 5'd3;
        #1;
        checks++;
        if (count !== 3'd1 || fwd_hit_a !== 1'b1 || fwd_data_a !== 64'd7) begin
            failures++;
            $display("FAIL x0_then_r3: got count=%0d hit=%b data=%0h, required 1/1/7", count, fwd_hit_a, fwd_data_a);
        end
        addr_a = 5'd0;
        #1;
        checks++;
        if (fwd_hit_a !== 1'b0 || fwd_data_a !== 64'd0) begin
            failures++;
            $display("FAIL x0_fwd: got hit=%b data=%0h, required 0/0", fwd_hit_a, fwd_data_a);
        end
        for (int i = 0; i < 3; i++) begin
            if (int'(count) > peak) peak = int'(count);
            tick();
        end
        checks++;
        if (peak !== 1 || sb.size() != 0) begin
            failures++;
            $display("FAIL x0_drain: got peak=%0d pending=%0d, required 1/0", peak, sb.size());
        end
    endtask

    task automatic test_fill_backpressure();
        drain_hold = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            in_valid = 1'b1; in_addr = 5'(i); in_data = 64'(i * 10);
            tick();
        end
        in_addr = 5'd5; in_data = 64'd50;
        #1;
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL fill_full: got full=%b rdy=%b count=%0d, required 1/0/4", full, in_ready, count);
        end
        tick();
        tick();
        checks++;
        if (count !== 3'd4 || write_en !== 1'b0) begin
            failures++;
            $display("FAIL fill_hold: got count=%0d en=%b, required 4/0", count, write_en);
        end
        in_valid = 1'b0;
        drain_hold = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checks++;
            if (write_en !== 1'b1 || write_addr !== 5'(i) || write_data !== 64'(i * 10)) begin
                failures++;
                $display("FAIL fill_drain%0d: got en=%b addr=%0d data=%0d, required 1/%0d/%0d",
                         i, write_en, write_addr, write_data, i, i * 10);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL fill_empty: got %b, required 1", empty);
        end
        tick();
    endtask

    task automatic test_forwarding();
        drain_hold = 1'b1;
        addr_a = 5'd7; addr_b = 5'd9;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 64'd1; tick();
        in_data = 64'd2; tick();
        in_addr = 5'd9; in_data = 64'd3; tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 64'd2 || fwd_hit_b !== 1'b1 || fwd_data_b !== 64'd3) begin
            failures++;
            $display("FAIL fwd_youngest: got a=%b/%0d b=%b/%0d, required 1/2 1/3", fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
        drain_hold = 1'b0;
        tick();
        drain_hold = 1'b1;
        #1;
        checks++;
        if (write_en !== 1'b1 || write_addr !== 5'd7 || fwd_hit_a !== 1'b1 || fwd_data_a !== 64'd2) begin
            failures++;
            $display("FAIL fwd_after_pop: got en=%b waddr=%0d hit=%b data=%0d, required 1/7/1/2", write_en, write_addr, fwd_hit_a, fwd_data_a);
        end
        addr_b = 5'd12;
        #1;
        checks++;
        if (fwd_hit_b !== 1'b0 || fwd_data_b !== 64'd0) begin
            failures++;
            $display("FAIL fwd_miss: got hit=%b data=%0d, required 0/0", fwd_hit_b, fwd_data_b);
        end
        drain_hold = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL fwd_drain: got pending=%0d empty=%b, required 0/1", sb.size(), empty);
        end
    endtask

    task automatic test_back_to_back();
        int start = n_writes;
        int peak = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_addr = 5'(i + 1); in_data = 64'(i);
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (peak > 2 || n_writes - start != 10 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_wrap: got peak=%0d writes=%0d pending=%0d, required <=2/10/0", peak, n_writes - start, sb.size());
        end
    endtask

    task automatic test_async_reset();
        drain_hold = 1'b1;
        addr_a = 5'd21; addr_b = 5'd24;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(21 + i); in_data = 64'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        drain_hold = 1'b0;
        tick();
        drain_hold = 1'b1;
        checks++;
        if (write_en !== 1'b1 || count !== 3'd3 || fwd_hit_a !== 1'b1 || fwd_hit_b !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: got en=%b count=%0d hits=%b%b, required 1/3/11", write_en, count, fwd_hit_a, fwd_hit_b);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (write_en !== 1'b0 || count !== 3'd0 || full !== 1'b0 || fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: got en=%b count=%0d full=%b hits=%b%b, required 0/0/0/00",
                     write_en, count, full, fwd_hit_a, fwd_hit_b);
        end
        sb.delete();
        tick();
        reset = 1'b1;
        drain_hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL areset_after: got count=%0d empty=%b, required 0/1", count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_x0_discard();
        test_fill_backpressure();
        test_forwarding();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, required finish before 100000");
        $fatal(1);
    end

endmodule
`default_nettype wire
